// File: rtl/ariane_irq_gateway_pkg.sv
// rtl/ariane_irq_gateway_pkg.sv - shared types and helpers for the interrupt gateway
package ariane_irq_gateway_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      GAP    = 2'd2
   } gw_state_e;

   localparam logic [63:0] DEFAULT_EDGE_MASK   = 64'd0;
   localparam logic [63:0] DEFAULT_INVERT_MASK = 64'd0;

   function automatic int id_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ariane_irq_gateway_chan.sv
// rtl/ariane_irq_gateway_chan.sv - one interrupt source: sync, edge detect, request FSM, edge queue
module ariane_irq_gateway_chan
   import ariane_irq_gateway_pkg::*;
#(
   parameter bit EDGE        = 1'b0,
   parameter bit INVERT      = 1'b0,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_WIDTH   = 3
) (
   input  logic aclk,
   input  logic areset,
   input  logic src_i,
   input  logic complete_i,
   input  logic overflow_clr_i,
   output logic irq_o,
   output logic overflow_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   q;
   logic                   q_prev;
   logic                   edge_det;
   gw_state_e              state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   ovf_d;
   logic                   inc, dec;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         sync_q <= '0;
         q_prev <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], src_i ^ INVERT};
         q_prev <= q;
      end
   end

   assign q        = sync_q[SYNC_STAGES-1];
   assign edge_det = EDGE & q & ~q_prev;

   // GAP re-arms directly from queued work so back-to-back requests see one low cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ovf_d   = overflow_o & ~overflow_clr_i;
      dec     = 1'b0;
      inc     = EDGE && edge_det && (state_q != IDLE);
      unique case (state_q)
         IDLE: begin
            if (EDGE) begin
               if (edge_det) begin
                  state_d = ACTIVE;
               end else if (cnt_q != '0) begin
                  state_d = ACTIVE;
                  dec     = 1'b1;
               end
            end else if (q) begin
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            if (complete_i) state_d = GAP;
         end
         GAP: begin
            state_d = IDLE;
            if (EDGE) begin
               if (cnt_q != '0) begin
                  state_d = ACTIVE;
                  dec     = 1'b1;
               end
            end else if (q) begin
               state_d = ACTIVE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (inc && !dec) begin
         if (cnt_q == CNT_MAX) ovf_d = 1'b1;
         else                  cnt_d = cnt_q + CNT_WIDTH'(1);
      end else if (dec && !inc) begin
         cnt_d = cnt_q - CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         irq_o      <= 1'b0;
         overflow_o <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         irq_o      <= (state_d == ACTIVE);
         overflow_o <= ovf_d;
      end
   end

endmodule

// File: rtl/ariane_irq_gateway.sv
// rtl/ariane_irq_gateway.sv - N-channel interrupt gateway in front of the PLIC
module ariane_irq_gateway
   import ariane_irq_gateway_pkg::*;
#(
   parameter int                  NUM_IRQS    = 4,
   parameter int                  SYNC_STAGES = 2,
   parameter logic [NUM_IRQS-1:0] EDGE_MASK   = DEFAULT_EDGE_MASK[NUM_IRQS-1:0],
   parameter logic [NUM_IRQS-1:0] INVERT_MASK = DEFAULT_INVERT_MASK[NUM_IRQS-1:0],
   parameter int                  CNT_WIDTH   = 3,
   localparam int                 ID_W        = id_width(NUM_IRQS)
) (
   input  logic                aclk,
   input  logic                areset,
   input  logic [NUM_IRQS-1:0] irq_src_i,
   output logic [NUM_IRQS-1:0] irq_o,
   input  logic                complete_valid_i,
   input  logic [ID_W-1:0]     complete_id_i,
   input  logic [NUM_IRQS-1:0] overflow_clr_i,
   output logic [NUM_IRQS-1:0] overflow_o
);

   logic [NUM_IRQS-1:0] complete_vec;

   // ids beyond NUM_IRQS-1 match no channel and are silently dropped
   for (genvar i = 0; i < NUM_IRQS; i++) begin : g_chan
      assign complete_vec[i] = complete_valid_i && (complete_id_i == ID_W'(i));

      ariane_irq_gateway_chan #(
         .EDGE        (EDGE_MASK[i]),
         .INVERT      (INVERT_MASK[i]),
         .SYNC_STAGES (SYNC_STAGES),
         .CNT_WIDTH   (CNT_WIDTH)
      ) u_chan (
         .aclk           (aclk),
         .areset         (areset),
         .src_i          (irq_src_i[i]),
         .complete_i     (complete_vec[i]),
         .overflow_clr_i (overflow_clr_i[i]),
         .irq_o          (irq_o[i]),
         .overflow_o     (overflow_o[i])
      );
   end

endmodule
